// File: rtl/jtag_pa.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : jtag_pa (package)
// Description : Shared JTAG definitions. Holds the TAP state encodings, the
//               TAP state enum and a helper that tells whether a state lies
//               in the IR column.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pa;

  // Width of the IR/DR shift registers used by the downstream stages
  localparam int unsigned REG_W = 8;

  // TAP state encodings (all 16 codes of the 4-bit space are used)
  localparam logic [3:0] c_ENC_TLR      = 4'h0;
  localparam logic [3:0] c_ENC_RTI      = 4'h1;
  localparam logic [3:0] c_ENC_SEL_DR   = 4'h2;
  localparam logic [3:0] c_ENC_CAP_DR   = 4'h3;
  localparam logic [3:0] c_ENC_SHIFT_DR = 4'h4;
  localparam logic [3:0] c_ENC_EXIT1_DR = 4'h5;
  localparam logic [3:0] c_ENC_PAUSE_DR = 4'h6;
  localparam logic [3:0] c_ENC_EXIT2_DR = 4'h7;
  localparam logic [3:0] c_ENC_UPD_DR   = 4'h8;
  localparam logic [3:0] c_ENC_SEL_IR   = 4'h9;
  localparam logic [3:0] c_ENC_CAP_IR   = 4'hA;
  localparam logic [3:0] c_ENC_SHIFT_IR = 4'hB;
  localparam logic [3:0] c_ENC_EXIT1_IR = 4'hC;
  localparam logic [3:0] c_ENC_PAUSE_IR = 4'hD;
  localparam logic [3:0] c_ENC_EXIT2_IR = 4'hE;
  localparam logic [3:0] c_ENC_UPD_IR   = 4'hF;

  typedef enum logic [3:0] {
    TLR      = c_ENC_TLR,
    RTI      = c_ENC_RTI,
    SEL_DR   = c_ENC_SEL_DR,
    CAP_DR   = c_ENC_CAP_DR,
    SHIFT_DR = c_ENC_SHIFT_DR,
    EXIT1_DR = c_ENC_EXIT1_DR,
    PAUSE_DR = c_ENC_PAUSE_DR,
    EXIT2_DR = c_ENC_EXIT2_DR,
    UPD_DR   = c_ENC_UPD_DR,
    SEL_IR   = c_ENC_SEL_IR,
    CAP_IR   = c_ENC_CAP_IR,
    SHIFT_IR = c_ENC_SHIFT_IR,
    EXIT1_IR = c_ENC_EXIT1_IR,
    PAUSE_IR = c_ENC_PAUSE_IR,
    EXIT2_IR = c_ENC_EXIT2_IR,
    UPD_IR   = c_ENC_UPD_IR
  } tap_state_t;

  // True for Select-IR-Scan through Update-IR
  function automatic logic isIrColumn(input tap_state_t state);
    return (state >= SEL_IR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tapcontroller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : jtag_tapcontroller
// Description : IEEE 1149.1 TAP state machine. Advances on every rising TCK
//               edge under control of TMS and decodes one-hot state strobes
//               used as capture/shift/update enables by the IR/DR stages.
//               Optional: define JTAG_TAP_STATE_OUT_EN to expose the
//               registered state on o_state for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tapcontroller
  import jtag_pa::*;
(
  input  logic i_tclk,
  input  logic i_trst_n,
  input  logic i_tms,
  output logic o_stateIsTestLogicReset,
  output logic o_stateIsRunTestIdle,
  output logic o_stateIsCaptureDr,
  output logic o_stateIsShiftDr,
  output logic o_stateIsUpdateDr,
  output logic o_stateIsCaptureIr,
  output logic o_stateIsShiftIr,
  output logic o_stateIsUpdateIr,
  output logic o_selectIr,
  output logic o_tdoEn
`ifdef JTAG_TAP_STATE_OUT_EN
  ,
  output tap_state_t o_state
`endif
);

  tap_state_t r_state;
  tap_state_t w_next_state;

  // State register: synchronous active-low reset forces Test-Logic-Reset
  always_ff @(posedge i_tclk) begin
    if (!i_trst_n) r_state <= TLR;
    else           r_state <= w_next_state;
  end

  // Next-state logic: the standard TAP graph steered by TMS
  always_comb begin
    w_next_state = TLR;
    case (r_state)
      TLR:      w_next_state = i_tms ? TLR      : RTI;
      RTI:      w_next_state = i_tms ? SEL_DR   : RTI;
      SEL_DR:   w_next_state = i_tms ? SEL_IR   : CAP_DR;
      CAP_DR:   w_next_state = i_tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: w_next_state = i_tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: w_next_state = i_tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: w_next_state = i_tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: w_next_state = i_tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   w_next_state = i_tms ? SEL_DR   : RTI;
      SEL_IR:   w_next_state = i_tms ? TLR      : CAP_IR;
      CAP_IR:   w_next_state = i_tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: w_next_state = i_tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: w_next_state = i_tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: w_next_state = i_tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: w_next_state = i_tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   w_next_state = i_tms ? SEL_DR   : RTI;
      default:  w_next_state = TLR;
    endcase
  end

  // Moore output decode: strobes depend on the registered state only
  always_comb begin
    o_stateIsTestLogicReset = 1'b0;
    o_stateIsRunTestIdle    = 1'b0;
    o_stateIsCaptureDr      = 1'b0;
    o_stateIsShiftDr        = 1'b0;
    o_stateIsUpdateDr       = 1'b0;
    o_stateIsCaptureIr      = 1'b0;
    o_stateIsShiftIr        = 1'b0;
    o_stateIsUpdateIr       = 1'b0;
    case (r_state)
      TLR:      o_stateIsTestLogicReset = 1'b1;
      RTI:      o_stateIsRunTestIdle    = 1'b1;
      CAP_DR:   o_stateIsCaptureDr      = 1'b1;
      SHIFT_DR: o_stateIsShiftDr        = 1'b1;
      UPD_DR:   o_stateIsUpdateDr       = 1'b1;
      CAP_IR:   o_stateIsCaptureIr      = 1'b1;
      SHIFT_IR: o_stateIsShiftIr        = 1'b1;
      UPD_IR:   o_stateIsUpdateIr       = 1'b1;
      default:  ;
    endcase
    o_selectIr = isIrColumn(r_state);
    o_tdoEn    = (r_state == SHIFT_DR) || (r_state == SHIFT_IR);
  end

`ifdef JTAG_TAP_STATE_OUT_EN
  // Debug view of the registered state
  assign o_state = r_state;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_tapcontroller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_jtag_tapcontroller
// Description : Self-checking bench for jtag_tapcontroller. A column-based
//               reference model of the TAP graph predicts every output on
//               every cycle under directed and random TMS/reset stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tapcontroller;

  logic tclk = 1'b0;
  logic trst_n = 1'b0;
  logic tms = 1'b1;
  logic s_tlr, s_rti, s_cdr, s_sdr, s_udr, s_cir, s_sir, s_uir, sel_ir, tdo_en;
`ifdef JTAG_TAP_STATE_OUT_EN
  logic [3:0] dbg_state;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_state = 0;  // model state: 0 TLR, 1 RTI, 2..8 DR column, 9..15 IR column
  int cnt_cir, cnt_sir, cnt_udr, cnt_uir, cnt_selir;

  jtag_tapcontroller dut (
    .i_tclk                  (tclk),
    .i_trst_n                (trst_n),
    .i_tms                   (tms),
    .o_stateIsTestLogicReset (s_tlr),
    .o_stateIsRunTestIdle    (s_rti),
    .o_stateIsCaptureDr      (s_cdr),
    .o_stateIsShiftDr        (s_sdr),
    .o_stateIsUpdateDr       (s_udr),
    .o_stateIsCaptureIr      (s_cir),
    .o_stateIsShiftIr        (s_sir),
    .o_stateIsUpdateIr       (s_uir),
    .o_selectIr              (sel_ir),
    .o_tdoEn                 (tdo_en)
`ifdef JTAG_TAP_STATE_OUT_EN
    ,
    .o_state                 (dbg_state)
`endif
  );

  always #5 tclk = ~tclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Column position: 0 select, 1 capture, 2 shift, 3 exit1, 4 pause, 5 exit2, 6 update
  function automatic int nxt(input int s, input bit t);
    int base, p;
    if (s == 0) return t ? 0 : 1;
    if (s == 1) return t ? 2 : 1;
    base = (s >= 9) ? 9 : 2;
    p    = s - base;
    case (p)
      0:       return t ? ((base == 2) ? 9 : 0) : base + 1;
      1, 2:    return base + (t ? 3 : 2);
      3:       return base + (t ? 6 : 4);
      4:       return base + (t ? 5 : 4);
      5:       return base + (t ? 6 : 2);
      default: return t ? 2 : 1;
    endcase
  endfunction

  // Expected {tlr,rti,cdr,sdr,udr,cir,sir,uir,selIr,tdoEn}
  function automatic logic [9:0] exp_vec(input int s);
    bit ir;
    int p;
    ir = (s >= 9);
    p  = (s >= 9) ? s - 9 : s - 2;
    return {s == 0, s == 1,
            !ir && s >= 2 && p == 1, !ir && s >= 2 && p == 2, !ir && s >= 2 && p == 6,
            ir && p == 1, ir && p == 2, ir && p == 6,
            ir, (s >= 2) && p == 2};
  endfunction

  task automatic step(input bit t, input bit rst_n);
    @(negedge tclk);
    tms    = t;
    trst_n = rst_n;
    @(posedge tclk);
    m_state = rst_n ? nxt(m_state, t) : 0;
    #1;
    check($sformatf("outs_st%0d", m_state),
          {22'd0, s_tlr, s_rti, s_cdr, s_sdr, s_udr, s_cir, s_sir, s_uir, sel_ir, tdo_en},
          {22'd0, exp_vec(m_state)});
    cnt_cir   += int'(s_cir);
    cnt_sir   += int'(s_sir);
    cnt_udr   += int'(s_udr);
    cnt_uir   += int'(s_uir);
    cnt_selir += int'(sel_ir);
  endtask

  task automatic clr_counts();
    cnt_cir = 0; cnt_sir = 0; cnt_udr = 0; cnt_uir = 0; cnt_selir = 0;
  endtask

  // Random walk (under the model) until the target state is reached
  task automatic goto_state(input int target);
    int guard;
    guard = 0;
    while (m_state != target && guard < 2000) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      guard++;
    end
    if (m_state != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL reach_st%0d: got %0d expected %0d", target, m_state, target);
    end
  endtask

  initial begin
    bit dr_seq [10];
    dr_seq = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 1};
    clr_counts();

    // Reset held two edges with TMS high
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_tlr", {31'd0, s_tlr}, 32'd1);

    // Into Shift-IR: 0,1,1,0,0
    clr_counts();
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    check("cap_ir_len", cnt_cir, 1);
    check("shir_tdoen", {30'd0, tdo_en, sel_ir}, 32'd3);

    // Stay in Shift-IR four more edges, then exit through Update-IR to RTI
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    check("upd_ir_now", {31'd0, s_uir}, 32'd1);
    step(1'b0, 1'b1);
    check("shift_ir_len", cnt_sir, 5);
    check("upd_ir_len", cnt_uir, 1);
    check("rti_after_ir", {31'd0, s_rti}, 32'd1);

    // DR path with pause
    clr_counts();
    foreach (dr_seq[i]) step(dr_seq[i], 1'b1);
    check("upd_dr_once", cnt_udr, 1);
    check("dr_selir_low", cnt_selir, 0);
    check("dr_end_upd", {31'd0, s_udr}, 32'd1);

    // Five TMS=1 edges reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      goto_state(s);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
      check($sformatf("tms5_from_%0d", s), {31'd0, s_tlr}, 32'd1);
    end

    // Reset while in Shift-DR: no Update-DR strobe
    goto_state(4);
    clr_counts();
    step(1'b0, 1'b0);
    check("rst_mid_shift", {30'd0, s_tlr, s_sdr}, 32'd2);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    check("no_upd_dr", cnt_udr, 0);

    // Random TMS with occasional reset
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
